// File: rtl/frontend_fetch_queue.sv
// Fetch queue between IFU and IDU: multi-lane enqueue, single-entry dequeue, flush clears all.
// Optional same-cycle empty-queue bypass of lane 0 under `define FRONTEND_FETCH_QUEUE_BYPASS_EN.
module frontend_fetch_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ENQ_WIDTH = 2,
    parameter int unsigned EXC_W     = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [ENQ_WIDTH-1:0]              enq_valid,
    output logic                              enq_ready,
    input  logic [ENQ_WIDTH-1:0][31:0]        enq_pc,
    input  logic [ENQ_WIDTH-1:0][31:0]        enq_inst,
    input  logic [ENQ_WIDTH-1:0][EXC_W-1:0]   enq_exc,
    input  logic [ENQ_WIDTH-1:0][31:0]        enq_except_val,
    input  logic [ENQ_WIDTH-1:0][31:0]        enq_pred_target,
    input  logic [ENQ_WIDTH-1:0]              enq_pred_valid,
    output logic                              deq_valid,
    input  logic                              deq_ready,
    output logic [31:0]                       deq_pc,
    output logic [31:0]                       deq_inst,
    output logic [EXC_W-1:0]                  deq_exc,
    output logic [31:0]                       deq_except_val,
    output logic [31:0]                       deq_pred_target,
    output logic                              deq_pred_valid,
    output logic [$clog2(DEPTH):0]            occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [EXC_W-1:0] exc;
        logic [31:0]      except_val;
        logic [31:0]      pred_target;
        logic             pred_valid;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    entry_t             lane_entry [ENQ_WIDTH];
    entry_t             head_entry;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, wr_idx;
    logic [CNT_W-1:0]   count_q, count_d, n_store;
    logic [ENQ_WIDTH:0] lane_ok;
    logic [ENQ_WIDTH-1:0] wr_en;
    logic               enq_fire, deq_fire, bypass, bypass_take;

    always_comb begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            lane_entry[i] = '{pc: enq_pc[i], inst: enq_inst[i], exc: enq_exc[i],
                              except_val: enq_except_val[i], pred_target: enq_pred_target[i],
                              pred_valid: enq_pred_valid[i]};
        end
    end

    // Space check uses only the registered count; a same-cycle dequeue frees nothing.
    assign enq_ready = (count_q <= CNT_W'(DEPTH - ENQ_WIDTH));
    assign enq_fire  = enq_ready && enq_valid[0];

    // A lane is kept only if every lower lane is valid and fault-free.
    always_comb begin
        lane_ok    = '0;
        wr_en      = '0;
        lane_ok[0] = 1'b1;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            wr_en[i]     = enq_fire && !flush && lane_ok[i] && enq_valid[i];
            lane_ok[i+1] = lane_ok[i] && enq_valid[i] && (enq_exc[i] == '0);
        end
    end

`ifdef FRONTEND_FETCH_QUEUE_BYPASS_EN
    assign bypass      = (count_q == '0) && enq_fire && !flush;
    assign bypass_take = bypass && deq_ready;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign deq_fire = (count_q != '0) && deq_ready && !flush;

    always_comb begin
        head_entry      = bypass ? lane_entry[0] : mem_q[head_q];
        deq_valid       = (count_q != '0) || bypass;
        deq_pc          = head_entry.pc;
        deq_inst        = head_entry.inst;
        deq_exc         = head_entry.exc;
        deq_except_val  = head_entry.except_val;
        deq_pred_target = head_entry.pred_target;
        deq_pred_valid  = head_entry.pred_valid;
        occupancy       = count_q;
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        n_store = '0;
        wr_idx  = '0;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // A bypassed-and-consumed lane 0 is never stored; later lanes shift down one slot.
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (wr_en[i] && !(bypass_take && i == 0)) begin
                    wr_idx        = tail_q + PTR_W'(i) - PTR_W'(bypass_take);
                    mem_d[wr_idx] = lane_entry[i];
                    n_store       = n_store + CNT_W'(1);
                end
            end
            tail_d  = tail_q + n_store[PTR_W-1:0];
            head_d  = head_q + PTR_W'(deq_fire);
            count_d = count_q + n_store - CNT_W'(deq_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifndef SYNTHESIS
    enq_valid_contiguous_a: assert property (@(posedge clk) disable iff (!rst_n)
        (((enq_valid >> 1) & ~enq_valid) == '0));
    count_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        (count_q <= CNT_W'(DEPTH)));
`endif

endmodule

// File: tb/tb_frontend_fetch_queue.sv
// Directed self-checking bench for frontend_fetch_queue (DEPTH=8, ENQ_WIDTH=2, EXC_W=16).
// Lane payload is derived from the PC so every dequeued field can be re-checked against it.
module tb_frontend_fetch_queue;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned ENQ_WIDTH = 2;
    localparam int unsigned EXC_W     = 16;

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic                            flush;
    logic [ENQ_WIDTH-1:0]            enq_valid;
    logic                            enq_ready;
    logic [ENQ_WIDTH-1:0][31:0]      enq_pc;
    logic [ENQ_WIDTH-1:0][31:0]      enq_inst;
    logic [ENQ_WIDTH-1:0][EXC_W-1:0] enq_exc;
    logic [ENQ_WIDTH-1:0][31:0]      enq_except_val;
    logic [ENQ_WIDTH-1:0][31:0]      enq_pred_target;
    logic [ENQ_WIDTH-1:0]            enq_pred_valid;
    logic                            deq_valid;
    logic                            deq_ready;
    logic [31:0]                     deq_pc;
    logic [31:0]                     deq_inst;
    logic [EXC_W-1:0]                deq_exc;
    logic [31:0]                     deq_except_val;
    logic [31:0]                     deq_pred_target;
    logic                            deq_pred_valid;
    logic [$clog2(DEPTH):0]          occupancy;

    int n_cmp = 0;
    int n_err = 0;

    frontend_fetch_queue #(
        .DEPTH    (DEPTH),
        .ENQ_WIDTH(ENQ_WIDTH),
        .EXC_W    (EXC_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_pc         (enq_pc),
        .enq_inst       (enq_inst),
        .enq_exc        (enq_exc),
        .enq_except_val (enq_except_val),
        .enq_pred_target(enq_pred_target),
        .enq_pred_valid (enq_pred_valid),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_pc         (deq_pc),
        .deq_inst       (deq_inst),
        .deq_exc        (deq_exc),
        .deq_except_val (deq_except_val),
        .deq_pred_target(deq_pred_target),
        .deq_pred_valid (deq_pred_valid),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic [15:0] exc);
        enq_pc[i]          = pc;
        enq_inst[i]        = pc ^ 32'hdead_0000;
        enq_exc[i]         = exc;
        enq_except_val[i]  = pc + 32'd1;
        enq_pred_target[i] = pc + 32'h40;
        enq_pred_valid[i]  = pc[2];
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [15:0] x0, input logic [15:0] x1);
        enq_valid = v;
        set_lane(0, pc0, x0);
        set_lane(1, pc1, x1);
    endtask

    task automatic idle();
        drive(2'b00, 32'd0, 32'd0, 16'd0, 16'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] sb[$];
        logic [31:0] pc;
        logic        exp_ready, exp_valid;
        int          sent, cyc;

        rst_n = 1'b0;
        flush = 1'b0;
        deq_ready = 1'b0;
        idle();
        #12;
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_deq_pc", 64'(deq_pc), 64'd0);
        chk("rst_deq_exc", 64'(deq_exc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill to DEPTH with no dequeue.
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 32'h1000 + 32'(8 * k), 32'h1004 + 32'(8 * k), 16'd0, 16'd0);
            tick();
            chk("fill_occupancy", 64'(occupancy), 64'(2 * (k + 1)));
        end
        drive(2'b11, 32'h2000, 32'h2004, 16'd0, 16'd0);
        #1;
        chk("full_enq_ready", 64'(enq_ready), 64'd0);
        chk("full_deq_valid", 64'(deq_valid), 64'd1);
        chk("full_deq_pc", 64'(deq_pc), 64'h1000);
        tick();
        chk("full_refuse_occ", 64'(occupancy), 64'd8);

        // Drain in order; enq_ready returns once count <= DEPTH-ENQ_WIDTH.
        idle();
        deq_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_deq_pc", 64'(deq_pc), 64'h1000 + 64'(4 * k));
            tick();
            if (k == 0) begin
                chk("drain7_occ", 64'(occupancy), 64'd7);
                chk("drain7_enq_ready", 64'(enq_ready), 64'd0);
            end
            if (k == 1) begin
                chk("drain6_enq_ready", 64'(enq_ready), 64'd1);
            end
        end
        chk("drained_deq_valid", 64'(deq_valid), 64'd0);
        chk("drained_occ", 64'(occupancy), 64'd0);

        // Two-entry packet drained on consecutive cycles.
        deq_ready = 1'b0;
        drive(2'b11, 32'h8000_0000, 32'h8000_0004, 16'd0, 16'd0);
        tick();
        idle();
        deq_ready = 1'b1;
        #1;
        chk("pair_valid0", 64'(deq_valid), 64'd1);
        chk("pair_pc0", 64'(deq_pc), 64'h8000_0000);
        tick();
        chk("pair_valid1", 64'(deq_valid), 64'd1);
        chk("pair_pc1", 64'(deq_pc), 64'h8000_0004);
        tick();
        chk("pair_empty", 64'(deq_valid), 64'd0);

        // Faulting lane 0 discards lane 1.
        deq_ready = 1'b0;
        drive(2'b11, 32'h5000, 32'h5004, 16'h0004, 16'h0000);
        tick();
        idle();
        #1;
        chk("exc_occ", 64'(occupancy), 64'd1);
        chk("exc_pc", 64'(deq_pc), 64'h5000);
        chk("exc_bits", 64'(deq_exc), 64'h0004);
        chk("exc_val", 64'(deq_except_val), 64'h5001);
        deq_ready = 1'b1;
        tick();
        chk("exc_after_occ", 64'(occupancy), 64'd0);
        deq_ready = 1'b0;

        // Flush wins over simultaneous enqueue and dequeue.
        drive(2'b11, 32'h6000, 32'h6004, 16'd0, 16'd0);
        tick();
        drive(2'b11, 32'h6008, 32'h600c, 16'd0, 16'd0);
        tick();
        drive(2'b01, 32'h6010, 32'h0, 16'd0, 16'd0);
        tick();
        idle();
        #1;
        chk("preflush_occ", 64'(occupancy), 64'd5);
        drive(2'b11, 32'h7000, 32'h7004, 16'd0, 16'd0);
        deq_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        deq_ready = 1'b0;
        idle();
        #1;
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_deq_valid", 64'(deq_valid), 64'd0);
        drive(2'b11, 32'h3000, 32'h3004, 16'd0, 16'd0);
        tick();
        idle();
        #1;
        chk("postflush_occ", 64'(occupancy), 64'd2);
        chk("postflush_pc0", 64'(deq_pc), 64'h3000);
        deq_ready = 1'b1;
        tick();
        chk("postflush_pc1", 64'(deq_pc), 64'h3004);
        tick();
        chk("postflush_empty", 64'(occupancy), 64'd0);

        // 20 packets with random back-pressure; order and sideband pairing across wraps.
        sent = 0;
        cyc = 0;
        while ((sent < 20 || sb.size() != 0) && cyc < 600) begin
            deq_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                drive(2'b11, 32'h4000 + 32'(8 * sent), 32'h4004 + 32'(8 * sent), 16'd0, 16'd0);
            end else begin
                idle();
            end
            #1;
            exp_ready = (DEPTH - sb.size()) >= ENQ_WIDTH;
            chk("rnd_enq_ready", 64'(enq_ready), 64'(exp_ready));
            exp_valid = (sb.size() != 0);
`ifdef FRONTEND_FETCH_QUEUE_BYPASS_EN
            exp_valid = exp_valid || (exp_ready && enq_valid[0]);
`endif
            chk("rnd_deq_valid", 64'(deq_valid), 64'(exp_valid));
            if (exp_ready && enq_valid[0]) begin
                sb.push_back(enq_pc[0]);
                sb.push_back(enq_pc[1]);
                sent++;
            end
            if (exp_valid && deq_ready && sb.size() != 0) begin
                pc = sb.pop_front();
                chk("rnd_pc", 64'(deq_pc), 64'(pc));
                chk("rnd_inst", 64'(deq_inst), 64'(pc ^ 32'hdead_0000));
                chk("rnd_pred_target", 64'(deq_pred_target), 64'(pc + 32'h40));
                chk("rnd_pred_valid", 64'(deq_pred_valid), 64'(pc[2]));
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rnd_all_sent", 64'(sent), 64'd20);
        chk("rnd_sb_drained", 64'(sb.size()), 64'd0);
        idle();
        deq_ready = 1'b0;
        #1;
        chk("rnd_end_occ", 64'(occupancy), 64'd0);

`ifdef FRONTEND_FETCH_QUEUE_BYPASS_EN
        drive(2'b11, 32'h100, 32'h104, 16'd0, 16'd0);
        deq_ready = 1'b1;
        #1;
        chk("byp_deq_valid", 64'(deq_valid), 64'd1);
        chk("byp_deq_pc", 64'(deq_pc), 64'h100);
        tick();
        idle();
        deq_ready = 1'b0;
        #1;
        chk("byp_occ", 64'(occupancy), 64'd1);
        chk("byp_next_pc", 64'(deq_pc), 64'h104);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
`endif

        // Asynchronous reset mid-operation.
        drive(2'b11, 32'h9000, 32'h9004, 16'd0, 16'd0);
        tick();
        idle();
        #1;
        chk("pre_arst_occ", 64'(occupancy), 64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_deq_valid", 64'(deq_valid), 64'd0);
        chk("arst_deq_pc", 64'(deq_pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
